matrix_ram_loader: RTL and testbench
====================================

# matrix_ram_loader

Writer side of the shared 64x32 `DataRam` used by the matrix inverter. It accepts an N×N matrix of 32-bit integers as a row-major valid/ready stream and writes the augmented matrix [A | I] into the RAM. Row r goes to addresses r·2N … r·2N+2N−1. When the last word is written, it pulses `start` to launch the inverter. It then holds off the next matrix while the inverter reports busy.

## Interface
Parameters:
- `N`, 5: matrix order. The RAM row stride is 2N.
- `DW`, 32: data width.
- `AW`, 6: RAM address width. Requires 2·N·N ≤ 2^AW.

Ports:
- `clk`  in  1  clock. One clock domain only.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  a matrix element is offered.
- `in_data`  in  DW  element, signed two's complement, row-major.
- `in_ready`  out  1  element accepted when `in_valid && in_ready`.
- `inv_busy`  in  1  inverter is running; blocks the first element of the next matrix.
- `ram_we`  out  1  RAM write enable (drives `wea`).
- `ram_addr`  out  AW  RAM address (drives `addra`).
- `ram_din`  out  DW  RAM write data (drives `dina`).
- `start`  out  1  one-cycle pulse: the augmented matrix is complete in RAM.
- `pivot_zero`  out  1  sticky flag: a diagonal element A[r][r] of the current matrix was 0 (see Configuration).

## Operation
- Reset values:
  - `in_ready`, `ram_we`, `start`, `pivot_zero` = 0; `ram_addr`, `ram_din` = 0.
  - Row, column and address counters = 0; state = S_IDLE.
- States:
  - S_IDLE: `in_ready = !inv_busy`. On an accepted beat, write the element at address 0 and go to S_A with col = 1.
  - S_A: `in_ready = 1`. Each accepted beat writes `in_data` at `addr` and increments col and addr. After the beat at col N−1, go to S_I.
    - `in_valid` low: no write; counters and state hold.
  - S_I: `in_ready = 0`. Writes one identity word per cycle for col = N … 2N−1, with value 1 when col−N == row, else 0. Increments addr each cycle.
    - After col 2N−1: if row < N−1, increment row, set col = 0 and go to S_A.
    - Otherwise go to S_START.
  - S_START: `in_ready = 0`. `start` is registered high for exactly one cycle. Counters clear; go to S_IDLE.
- `pivot_zero` clears on the first accepted beat of a new matrix.
- Address arithmetic is a free-running AW-bit counter. It never wraps within one matrix; its final value is 2N·N−1 (49 for N = 5).
- Mid-operation reset: the partial matrix is abandoned and `start` is not issued. RAM contents are not cleared.
- The inverter must raise `inv_busy` no later than the cycle after `start`. An element offered in that cycle is not accepted.

## Timing
- `ram_we`, `ram_addr`, `ram_din` and `start` are registered.
- A beat accepted in cycle t produces its RAM write in cycle t+1. Identity words likewise appear one cycle after their S_I cycle.
- With `in_valid` held high and N = 5:
  - Beats are accepted in cycles 0–4, 10–14, 20–24, 30–34, 40–44.
  - `ram_we` is high in cycles 1–50 continuously: 50 writes to addresses 0–49 in order.
  - `start` is high in cycle 51 only.
- `ram_we` is never high in the same cycle as `start`.
- Throughput is one matrix per 2N² + 2 cycles plus the inverter's busy time.

## Configuration
- `MATRIX_LOADER_PIVOT_CHECK_EN`
  - Defined: each accepted beat with col == row and `in_data == 0` sets `pivot_zero`. It stays set until the next matrix's first beat or reset.
  - Undefined: `pivot_zero` is tied to 0 and no comparator is built. All other behaviour is identical.

## Structure
- Shared package `matrix_pkg`:
  - `MAT_N` = 5, `MAT_DW` = 32, `MAT_AW` = 6.
  - The state enum `loader_state_t` (S_IDLE, S_A, S_I, S_START).
  - The function `aug_addr(row, col)` = row·2N + col, also used by the bench.
- One natural sub-module, `aug_index_counter`: row/col/addr counters with enable and clear, which flags the last column and last row.

## Test plan
- Matrix 1..25 streamed with `in_valid` always high:
  - 50 writes; addr 0 = 1, addr 4 = 5, addr 5 = 1, addr 6–9 = 0, addr 10 = 6, addr 16 = 1, addr 49 = 1.
  - `start` high only in cycle 51.
- Same matrix with `in_valid` low every other cycle: identical RAM image. No `ram_we` in a cycle following a non-accepted S_A cycle.
- `inv_busy` held high for 20 cycles after `start`, second matrix offered:
  - `in_ready` stays 0 through the 20 cycles.
  - First accept in the cycle `inv_busy` falls; second matrix overwrites addresses 0–49.
- `rst` asserted at the 13th accepted beat:
  - All outputs are 0 immediately; no `start`.
  - The next matrix begins at address 0.
- Negative and extreme values (−1, 0x80000000, 0x7FFFFFFF) are written unmodified to their addresses.
- With the macro defined, A[2][2] = 0: `pivot_zero` rises in the cycle after that beat, holds through `start`, and clears on the next matrix's first beat. Without the macro it stays 0.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix inverter's RAM loader: sizes, loader FSM states
// and the augmented-matrix address map.
package matrix_pkg;

   localparam int MAT_N  = 5;
   localparam int MAT_DW = 32;
   localparam int MAT_AW = 6;

   typedef enum logic [1:0] {S_IDLE, S_A, S_I, S_START} loader_state_t;

   // Row r of [A | I] occupies 2N consecutive words starting at r*2N.
   function automatic logic [MAT_AW-1:0] aug_addr(input int row, input int col);
      return MAT_AW'(row * 2 * MAT_N + col);
   endfunction

endpackage

// File: rtl/aug_index_counter.sv
// Row/column/address counters for walking the augmented matrix [A | I] in row-major
// order, with flags for the last A column, the last augmented column and the last row.
module aug_index_counter #(
   parameter int N  = 5,
   parameter int AW = 6,
   parameter int RW = 3,
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          clr,
   output logic [RW-1:0] row,
   output logic [CW-1:0] col,
   output logic [AW-1:0] addr,
   output logic          a_last,
   output logic          i_last,
   output logic          row_last
);

   assign a_last   = (col == CW'(N - 1));
   assign i_last   = (col == CW'(2 * N - 1));
   assign row_last = (row == RW'(N - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row  <= '0;
         col  <= '0;
         addr <= '0;
      end else if (clr) begin
         row  <= '0;
         col  <= '0;
         addr <= '0;
      end else if (en) begin
         addr <= addr + AW'(1);
         if (i_last) begin
            col <= '0;
            row <= row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

endmodule

// File: rtl/matrix_ram_loader.sv
// Streams an NxN matrix into the shared DataRam as [A | I] and pulses start for the inverter.
// Optional diagonal-zero detection is built when MATRIX_LOADER_PIVOT_CHECK_EN is defined.
module matrix_ram_loader
   import matrix_pkg::*;
#(
   parameter int N  = MAT_N,
   parameter int DW = MAT_DW,
   parameter int AW = MAT_AW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic signed [DW-1:0] in_data,
   output logic                 in_ready,
   input  logic                 inv_busy,
   output logic                 ram_we,
   output logic [AW-1:0]        ram_addr,
   output logic signed [DW-1:0] ram_din,
   output logic                 start,
   output logic                 pivot_zero
);

   // Row counter briefly reaches N on the final wrap before S_START clears it.
   localparam int RW = $clog2(N + 1);
   localparam int CW = $clog2(2 * N);

   loader_state_t st, nxt;

   logic [RW-1:0]        row;
   logic [CW-1:0]        col;
   logic [AW-1:0]        addr;
   logic                 a_last, i_last, row_last;
   logic                 cnt_en, cnt_clr;
   logic                 wr, start_set, id_hit, idle_ok;
   logic signed [DW-1:0] wdata;

   logic                 we_p1, start_p1;
   logic [AW-1:0]        addr_p1;
   logic signed [DW-1:0] din_p1;

   aug_index_counter #(
      .N  (N),
      .AW (AW),
      .RW (RW),
      .CW (CW)
   ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .en       (cnt_en),
      .clr      (cnt_clr),
      .row      (row),
      .col      (col),
      .addr     (addr),
      .a_last   (a_last),
      .i_last   (i_last),
      .row_last (row_last)
   );

   assign id_hit = ((int'(col) - N) == int'(row));

   // idle_ok keeps in_ready low while reset is held; the start cycle itself is also
   // closed so the inverter always has the following cycle to raise inv_busy.
   always_comb begin
      nxt       = st;
      in_ready  = 1'b0;
      wr        = 1'b0;
      wdata     = in_data;
      cnt_en    = 1'b0;
      cnt_clr   = 1'b0;
      start_set = 1'b0;
      case (st)
         S_IDLE: begin
            in_ready = idle_ok && !start_p1 && !inv_busy;
            if (in_valid && in_ready) begin
               wr     = 1'b1;
               cnt_en = 1'b1;
               nxt    = a_last ? S_I : S_A;
            end
         end
         S_A: begin
            in_ready = 1'b1;
            if (in_valid) begin
               wr     = 1'b1;
               cnt_en = 1'b1;
               if (a_last) nxt = S_I;
            end
         end
         S_I: begin
            wr     = 1'b1;
            wdata  = id_hit ? DW'(1) : '0;
            cnt_en = 1'b1;
            if (i_last) nxt = row_last ? S_START : S_A;
         end
         S_START: begin
            cnt_clr   = 1'b1;
            start_set = 1'b1;
            nxt       = S_IDLE;
         end
         default: nxt = S_IDLE;
      endcase
   end

   // Stage p1: registered RAM port and start pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st       <= S_IDLE;
         idle_ok  <= 1'b0;
         we_p1    <= 1'b0;
         start_p1 <= 1'b0;
         addr_p1  <= '0;
         din_p1   <= '0;
      end else begin
         st       <= nxt;
         idle_ok  <= 1'b1;
         we_p1    <= wr;
         start_p1 <= start_set;
         if (wr) begin
            addr_p1 <= addr;
            din_p1  <= wdata;
         end
      end
   end

   assign ram_we   = we_p1;
   assign ram_addr = addr_p1;
   assign ram_din  = din_p1;
   assign start    = start_p1;

`ifdef MATRIX_LOADER_PIVOT_CHECK_EN
   logic accept, first_beat, diag_zero, pz_p1;

   assign accept     = in_valid && in_ready;
   assign first_beat = accept && (st == S_IDLE);
   assign diag_zero  = accept && (int'(col) == int'(row)) && (in_data == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pz_p1 <= 1'b0;
      end else if (accept) begin
         pz_p1 <= diag_zero || (pz_p1 && !first_beat);
      end
   end

   assign pivot_zero = pz_p1;
`else
   assign pivot_zero = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_ram_loader.sv
// Directed self-checking bench for matrix_ram_loader (N = 5); pivot checks follow
// MATRIX_LOADER_PIVOT_CHECK_EN when it is defined for the build.
module tb_matrix_ram_loader;
   import matrix_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_ready;
   logic        inv_busy = 1'b0;
   logic        ram_we;
   logic [5:0]  ram_addr;
   logic [31:0] ram_din;
   logic        start;
   logic        pivot_zero;

   int total = 0;
   int fails = 0;
   int cyc = 0;
   int cur [0:24];

   // monitor state (written only by the monitor process)
   logic        mon_clr = 1'b0;
   logic [31:0] mem [0:63];
   int acc_log [0:63];
   int acc_n, we_n, start_n, overlap, order_err, exp_addr;
   int we_first, we_last, start_cyc, pz_rise, pz_fall;
   logic pz_any, pz_start, pz_prev = 1'b0;
   logic rdy_during;

   matrix_ram_loader dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .inv_busy   (inv_busy),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_din    (ram_din),
      .start      (start),
      .pivot_zero (pivot_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mon_clr) begin
         acc_n = 0; we_n = 0; start_n = 0; overlap = 0; order_err = 0; exp_addr = 0;
         we_first = -1; we_last = -1; start_cyc = -1; pz_rise = -1; pz_fall = -1;
         pz_any = 1'b0; pz_start = 1'b0;
         for (int i = 0; i < 64; i++) mem[i] = 'x;
      end else begin
         if (in_valid && in_ready) begin
            if (acc_n < 64) acc_log[acc_n] = cyc;
            acc_n++;
         end
         if (ram_we) begin
            mem[ram_addr] = ram_din;
            if (int'(ram_addr) != exp_addr) order_err++;
            exp_addr = (exp_addr + 1) % 50;
            if (we_n == 0) we_first = cyc;
            we_last = cyc;
            we_n++;
         end
         if (start) begin
            start_n++;
            start_cyc = cyc;
            pz_start = pivot_zero;
         end
         if (ram_we && start) overlap++;
         if (pivot_zero) begin
            pz_any = 1'b1;
            if (pz_rise < 0) pz_rise = cyc;
         end else if (pz_prev && pz_fall < 0) begin
            pz_fall = cyc;
         end
      end
      pz_prev = pivot_zero;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic mon_reset();
      mon_clr = 1'b1;
      @(negedge clk);
      #1 mon_clr = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic load_seq(input int base);
      for (int k = 0; k < 25; k++) cur[k] = base + k;
   endtask

   // mode 0: in_valid held high; mode 1: in_valid high every other cycle.
   // abort_at > 0 asserts rst right after that many beats were accepted.
   task automatic send(input int mode, input int abort_at);
      int idx = 0;
      int c = 0;
      logic acc;
      while (idx < 25 && c < 400) begin
         in_valid = (mode == 0) || (c % 2 == 0);
         in_data  = cur[idx];
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk);
         #1;
         c++;
         if (acc) begin
            idx++;
            if (idx == abort_at) begin
               rst = 1'b1;
               in_valid = 1'b0;
               return;
            end
         end
      end
      in_valid = 1'b0;
      chk("send_done", idx, 25);
   endtask

   task automatic wait_start(input int n);
      int w = 0;
      while (start_n < n && w < 300) begin
         @(posedge clk);
         #1;
         w++;
      end
      chk("start_seen", start_n >= n, 1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int bad;
      int ev;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_din", ram_din, 0);
      chk("rst_start", start, 0);
      chk("rst_pivot", pivot_zero, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // matrix 1..25, in_valid always high
      mon_reset();
      load_seq(1);
      send(0, 0);
      wait_start(1);
      bad = 0;
      for (int k = 0; k < 25; k++)
         if (acc_log[k] - acc_log[0] != (k / 5) * 10 + k % 5) bad++;
      chk("acc_pattern", bad, 0);
      chk("we_count", we_n, 50);
      chk("we_first", we_first - acc_log[0], 1);
      chk("we_last", we_last - acc_log[0], 50);
      chk("start_count", start_n, 1);
      chk("start_cycle", start_cyc - acc_log[0], 51);
      chk("we_start_overlap", overlap, 0);
      chk("addr_order", order_err, 0);
      chk("mem0", mem[0], 1);
      chk("mem4", mem[4], 5);
      chk("mem5", mem[5], 1);
      for (int a = 6; a < 10; a++) chk("mem6_9", mem[a], 0);
      chk("mem10", mem[10], 6);
      chk("mem16", mem[16], 1);
      chk("mem49", mem[49], 1);

      // same matrix, in_valid low every other cycle
      mon_reset();
      send(1, 0);
      wait_start(1);
      bad = 0;
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 10; c++) begin
            ev = (c < 5) ? cur[r * 5 + c] : ((c - 5 == r) ? 1 : 0);
            if (mem[aug_addr(r, c)] !== 32'(ev)) bad++;
         end
      chk("alt_image", bad, 0);
      chk("alt_we_count", we_n, 50);
      chk("alt_addr_order", order_err, 0);

      // inverter busy for 20 cycles after start, second matrix already offered
      mon_reset();
      rdy_during = 1'b0;
      fork
         begin
            load_seq(1);
            send(0, 0);
            load_seq(101);
            send(0, 0);
         end
         begin
            int w = 0;
            while (!start && w < 300) begin
               @(negedge clk);
               w++;
            end
            @(posedge clk);
            #1 inv_busy = 1'b1;
            for (int i = 0; i < 20; i++) begin
               @(negedge clk);
               rdy_during = rdy_during | in_ready;
               @(posedge clk);
               #1;
            end
            inv_busy = 1'b0;
         end
      join
      wait_start(2);
      chk("busy_ready_low", rdy_during, 0);
      chk("busy_first_accept", acc_log[25] - acc_log[0], 72);
      chk("busy_start_count", start_n, 2);
      chk("busy_we_count", we_n, 100);
      chk("busy_addr_order", order_err, 0);
      chk("busy_mem0", mem[0], 101);
      chk("busy_mem4", mem[4], 105);
      chk("busy_mem10", mem[10], 106);
      chk("busy_mem49", mem[49], 1);

      // reset at the 13th accepted beat
      mon_reset();
      load_seq(1);
      send(0, 13);
      #1;
      chk("abort_in_ready", in_ready, 0);
      chk("abort_ram_we", ram_we, 0);
      chk("abort_ram_addr", ram_addr, 0);
      chk("abort_ram_din", ram_din, 0);
      chk("abort_start", start, 0);
      chk("abort_pivot", pivot_zero, 0);
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      repeat (60) @(posedge clk);
      #1;
      chk("abort_no_start", start_n, 0);
      mon_reset();
      send(0, 0);
      wait_start(1);
      chk("restart_addr_order", order_err, 0);
      chk("restart_we_count", we_n, 50);
      chk("restart_mem0", mem[0], 1);
      chk("restart_mem12", mem[12], 8);

      // extreme values with A[2][2] = 0
      mon_reset();
      load_seq(1);
      cur[0]  = -1;
      cur[8]  = 32'h8000_0000;
      cur[12] = 0;
      cur[24] = 32'h7FFF_FFFF;
      send(0, 0);
      wait_start(1);
      chk("ext_minus1", mem[aug_addr(0, 0)], 32'hFFFF_FFFF);
      chk("ext_min", mem[aug_addr(1, 3)], 32'h8000_0000);
      chk("ext_zero", mem[aug_addr(2, 2)], 0);
      chk("ext_max", mem[aug_addr(4, 4)], 32'h7FFF_FFFF);
`ifdef MATRIX_LOADER_PIVOT_CHECK_EN
      chk("pivot_rise", pz_rise - acc_log[12], 1);
      chk("pivot_at_start", pz_start, 1);
      chk("pivot_held", pivot_zero, 1);
`else
      chk("pivot_off", pz_any, 0);
`endif

      // next matrix: sticky flag clears on its first beat
      mon_reset();
      load_seq(1);
      send(0, 0);
      wait_start(1);
`ifdef MATRIX_LOADER_PIVOT_CHECK_EN
      chk("pivot_clear", pz_fall - acc_log[0], 1);
      chk("pivot_stays_clear", pz_any, 0);
`else
      chk("pivot_off2", pz_any, 0);
`endif

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
